spi_master: RTL and testbench

- Single-byte SPI bus master, mode 0 (CPOL=0, CPHA=0), MSB first, one chip-select.
- On a start request it asserts CS, shifts data_in out on MOSI while shifting MISO in, then releases CS.
- It presents the received byte on data_out with a one-cycle done pulse.
- Sits between a local controller (start/data_in/data_out/done) and an off-chip SPI slave.

---
 rtl/spi_master.sv | 107 ++++++++++
 tb/tb_spi_master.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// Single-chip-select SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
// Launches one DATA_WIDTH-bit exchange per accepted start and pulses done with the received word.
module spi_master #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  MISO,
  output logic                  MOSI,
  output logic                  SCK,
  output logic                  CS,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  done
);

  localparam int               CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BITS     = CNT_W'(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, SETUP, TRANSFER, DONE} state_t;

  state_t                state;
  logic [7:0]            div_cnt;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-1:0] rx_shift;

  // tx_shift drains to zero after the last falling edge, so MOSI rests low outside a transfer
  assign MOSI = tx_shift[DATA_WIDTH-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      CS       <= 1'b1;
      SCK      <= 1'b0;
      done     <= 1'b0;
      data_out <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          SCK  <= 1'b0;
          if (start) begin
            tx_shift <= data_in;
            rx_shift <= '0;
            bit_cnt  <= '0;
            div_cnt  <= '0;
            CS       <= 1'b0;
            state    <= SETUP;
          end
        end

        SETUP: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            SCK      <= 1'b1;
            rx_shift <= {rx_shift[DATA_WIDTH-2:0], MISO};
            bit_cnt  <= bit_cnt + 1'b1;
            state    <= TRANSFER;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        TRANSFER: begin
          if (SCK) begin
            if (div_cnt == DIV_LAST) begin
              div_cnt  <= '0;
              SCK      <= 1'b0;
              tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end else if (bit_cnt == BITS) begin
            // the final low phase lasts one cycle: CS releases right after the last falling edge
            CS       <= 1'b1;
            done     <= 1'b1;
            data_out <= rx_shift;
            state    <= DONE;
          end else if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            SCK      <= 1'b1;
            rx_shift <= {rx_shift[DATA_WIDTH-2:0], MISO};
            bit_cnt  <= bit_cnt + 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Randomized scoreboard bench for spi_master: channel 0 runs CLK_DIV=1, channel 1 runs CLK_DIV=4.
// A slave model answers on MISO; a monitor checks every done against queued expectations.
module tb_spi_master;

  logic       clk;
  logic       reset;
  logic       start_v    [2];
  logic [7:0] data_in_v  [2];
  logic       miso_v     [2] = '{1'b0, 1'b0};
  logic       mosi_v     [2];
  logic       sck_v      [2];
  logic       cs_v       [2];
  logic [7:0] data_out_v [2];
  logic       done_v     [2];

  spi_master #(.DATA_WIDTH(8), .CLK_DIV(1)) dut (
    .clk(clk), .reset(reset), .start(start_v[0]), .data_in(data_in_v[0]), .MISO(miso_v[0]),
    .MOSI(mosi_v[0]), .SCK(sck_v[0]), .CS(cs_v[0]), .data_out(data_out_v[0]), .done(done_v[0])
  );

  spi_master #(.DATA_WIDTH(8), .CLK_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .start(start_v[1]), .data_in(data_in_v[1]), .MISO(miso_v[1]),
    .MOSI(mosi_v[1]), .SCK(sck_v[1]), .CS(cs_v[1]), .data_out(data_out_v[1]), .done(done_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         chan;
    logic [7:0] tx;
    logic [7:0] rx;
    int         gap;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   pass  = 0;

  function automatic int div_of(input int c);
    return (c == 0) ? 1 : 4;
  endfunction

  task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s ch%0d: got 0x%0h expected 0x%0h", name, c, act, exp);
  endtask

  // Slave: loads its reply word when CS falls, presents MSB first, advances on SCK falling.
  logic [7:0] slv_next [2];
  logic [7:0] s_sh     [2] = '{8'h00, 8'h00};
  logic       s_cs_p   [2] = '{1'b1, 1'b1};
  logic       s_sck_p  [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (!cs_v[c] && s_cs_p[c]) begin
        miso_v[c] = slv_next[c][7];
        s_sh[c]   = {slv_next[c][6:0], 1'b0};
      end else if (!cs_v[c] && !sck_v[c] && s_sck_p[c]) begin
        miso_v[c] = s_sh[c][7];
        s_sh[c]   = {s_sh[c][6:0], 1'b0};
      end
      s_cs_p[c]  = cs_v[c];
      s_sck_p[c] = sck_v[c];
    end
  end

  // Monitor: tracks SCK pulses, MOSI bits and CS timing, scores each done against the queue.
  logic       sck_p    [2] = '{1'b0, 1'b0};
  logic       cs_p     [2] = '{1'b1, 1'b1};
  logic       done_p   [2] = '{1'b0, 1'b0};
  int         hi_sck   [2] = '{0, 0};
  int         low_cs   [2] = '{0, 0};
  int         hi_cs    [2] = '{0, 0};
  int         pulses   [2] = '{0, 0};
  logic [7:0] cap      [2] = '{8'h00, 8'h00};
  logic [7:0] exp_dout [2] = '{8'h00, 8'h00};
  int         wait_cnt = 0;
  exp_t       e;

  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      wait_cnt = 0;
    end else if (exp_q.size() != 0) begin
      wait_cnt++;
      if (wait_cnt > 300) begin
        check("timeout", exp_q[0].chan, wait_cnt, 300);
        void'(exp_q.pop_front());
        wait_cnt = 0;
      end
    end
    for (int c = 0; c < 2; c++) begin
      if (!reset) begin
        check("reset_idle", c, {20'd0, cs_v[c], sck_v[c], mosi_v[c], done_v[c], data_out_v[c]}, 32'h800);
        exp_dout[c] = 8'h00;
        hi_cs[c]    = 0;
        low_cs[c]   = 0;
        pulses[c]   = 0;
      end else begin
        if (sck_v[c] && !sck_p[c]) begin
          cap[c] = {cap[c][6:0], mosi_v[c]};
          pulses[c]++;
          hi_sck[c] = 1;
        end else if (sck_v[c]) begin
          hi_sck[c]++;
        end
        if (!sck_v[c] && sck_p[c]) check("sck_high_len", c, hi_sck[c], div_of(c));

        if (!cs_v[c] && cs_p[c]) begin
          if (exp_q.size() == 0 || exp_q[0].chan != c) check("unexpected_cs_fall", c, 1, 0);
          else if (exp_q[0].gap != 0) check("cs_high_gap", c, hi_cs[c], exp_q[0].gap);
          low_cs[c] = 1;
          hi_cs[c]  = 0;
          pulses[c] = 0;
          cap[c]    = 8'h00;
        end else if (!cs_v[c]) begin
          low_cs[c]++;
        end else begin
          hi_cs[c]++;
        end

        if (done_v[c]) begin
          if (done_p[c]) check("done_consecutive", c, 1, 0);
          if (exp_q.size() == 0 || exp_q[0].chan != c) begin
            check("unexpected_done", c, 1, 0);
          end else begin
            e = exp_q.pop_front();
            wait_cnt = 0;
            check("cs_low_cycles", c, low_cs[c], 1 + 2 * 8 * div_of(c));
            check("done_cycle_pins", c, {28'd0, cs_p[c], cs_v[c], sck_v[c], mosi_v[c]}, 32'h4);
            check("sck_pulses", c, pulses[c], 8);
            check("mosi_word", c, cap[c], e.tx);
            check("data_out", c, data_out_v[c], e.rx);
            exp_dout[c] = e.rx;
          end
        end else begin
          check("data_out_hold", c, data_out_v[c], exp_dout[c]);
        end
      end
      sck_p[c]  = sck_v[c];
      cs_p[c]   = cs_v[c];
      done_p[c] = done_v[c];
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_cs(input int c, input logic lvl);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (cs_v[c] === lvl) break;
    end
  endtask

  task automatic xfer(input int c, input logic [7:0] din, input logic [7:0] sb, input int idle);
    exp_t t;
    t = '{chan: c, tx: din, rx: sb, gap: 0};
    data_in_v[c] = din;
    slv_next[c]  = sb;
    exp_q.push_back(t);
    start_v[c] = 1'b1;
    @(posedge clk); #1;
    start_v[c]   = 1'b0;
    data_in_v[c] = 8'($urandom);
    wait_idle();
    repeat (idle) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    exp_t t;
    int   rises;
    logic prev;

    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      start_v[c]   = 1'b1;
      data_in_v[c] = 8'hDB;
      slv_next[c]  = 8'h00;
    end
    #2 reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int c = 0; c < 2; c++) start_v[c] = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;

    xfer(0, 8'hFF, 8'hFF, 1);
    xfer(0, 8'hA5, 8'h3C, 0);
    repeat (6) xfer(0, 8'($urandom), 8'($urandom), $urandom_range(0, 3));

    // start held high: four back-to-back words
    t = '{chan: 0, tx: 8'($urandom), rx: 8'($urandom), gap: 0};
    data_in_v[0] = t.tx;
    slv_next[0]  = t.rx;
    exp_q.push_back(t);
    start_v[0] = 1'b1;
    wait_cs(0, 1'b0);
    for (int k = 1; k < 4; k++) begin
      t = '{chan: 0, tx: 8'($urandom), rx: 8'($urandom), gap: 2};
      data_in_v[0] = t.tx;
      slv_next[0]  = t.rx;
      exp_q.push_back(t);
      wait_cs(0, 1'b1);
      wait_cs(0, 1'b0);
    end
    start_v[0] = 1'b0;
    wait_idle();

    // abort after the fourth rising SCK edge
    xfer(0, 8'h5A, 8'hC3, 1);
    t = '{chan: 0, tx: 8'h96, rx: 8'h69, gap: 0};
    data_in_v[0] = t.tx;
    slv_next[0]  = t.rx;
    exp_q.push_back(t);
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    rises = 0;
    prev  = 1'b0;
    for (int i = 0; i < 200 && rises < 4; i++) begin
      @(posedge clk); #1;
      if (sck_v[0] && !prev) rises++;
      prev = sck_v[0];
    end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    xfer(0, 8'($urandom), 8'($urandom), 2);

    xfer(1, 8'h81, 8'($urandom), 1);
    xfer(1, 8'($urandom), 8'($urandom), 0);

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
